// File: rtl/shop_cmd_tx.sv
// Serialises one shop request into ASCII tokens, one per shop response, with a done pulse.
// Optional per-token response timeout is enabled by defining SHOP_TX_TIMEOUT_EN.
module shop_cmd_tx #(
  parameter int O_A_NUM_BITS   = 24,
  parameter int I_A_NUM_BITS   = 24,
  parameter int O_U_NUM_BITS   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [7:0] ERR_CHAR = "!",
  parameter logic [O_A_NUM_BITS-1:0] KEY_LOGOUT   = "LGO",
  parameter logic [O_A_NUM_BITS-1:0] KEY_LOGIN    = "LGI",
  parameter logic [O_A_NUM_BITS-1:0] KEY_ADD_USER = "ADU",
  parameter logic [O_A_NUM_BITS-1:0] KEY_DEL_USER = "DLU",
  parameter logic [O_A_NUM_BITS-1:0] KEY_ADD_ITEM = "ADI",
  parameter logic [O_A_NUM_BITS-1:0] KEY_DEL_ITEM = "DLI",
  parameter logic [O_A_NUM_BITS-1:0] KEY_BUY      = "BUY"
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [2:0]              i_req_op,
  input  logic [O_A_NUM_BITS-1:0] i_req_user,
  input  logic [O_A_NUM_BITS-1:0] i_req_arg,
  input  logic [O_U_NUM_BITS-1:0] i_req_num,
  output logic                    o_rdy,
  output logic [O_A_NUM_BITS-1:0] o_a,
  output logic [O_U_NUM_BITS-1:0] o_u,
  input  logic                    i_resp_vld,
  input  logic [I_A_NUM_BITS-1:0] i_resp,
  output logic [I_A_NUM_BITS-1:0] o_resp,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_DONE} state_e;

  typedef struct packed {
    logic [2:0]              op;
    logic [O_A_NUM_BITS-1:0] user;
    logic [O_A_NUM_BITS-1:0] arg;
    logic [O_U_NUM_BITS-1:0] num;
  } req_t;

  localparam int GW = $clog2((GAP_CYCLES > 1) ? GAP_CYCLES : 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  req_t                    req_q, req_d;
  logic [1:0]              idx_q, idx_d;
  logic [GW-1:0]           gcnt_q, gcnt_d;
  logic                    err_q, err_d;
  logic [I_A_NUM_BITS-1:0] resp_q, resp_d;

`ifdef SHOP_TX_TIMEOUT_EN
  localparam int TW = $clog2((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  logic [1:0]              last_idx;
  logic [O_A_NUM_BITS-1:0] tok;
  logic                    resp_err;

  assign resp_err = (i_resp[I_A_NUM_BITS-1 -: 8] == ERR_CHAR);

  // Index of the final token for the registered opcode.
  always_comb begin
    last_idx = 2'd1;
    case (req_q.op)
      3'd0:       last_idx = 2'd0;
      3'd1, 3'd2: last_idx = 2'd2;
      default:    last_idx = 2'd1;
    endcase
  end

  always_comb begin
    tok = req_q.arg;
    if (idx_q == 2'd0) begin
      case (req_q.op)
        3'd0:    tok = KEY_LOGOUT;
        3'd1:    tok = KEY_LOGIN;
        3'd2:    tok = KEY_ADD_USER;
        3'd3:    tok = KEY_DEL_USER;
        3'd4:    tok = KEY_ADD_ITEM;
        3'd5:    tok = KEY_DEL_ITEM;
        3'd6:    tok = KEY_BUY;
        default: tok = '0;
      endcase
    end else if (idx_q == 2'd1 && (req_q.op == 3'd1 || req_q.op == 3'd2 || req_q.op == 3'd3)) begin
      tok = req_q.user;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    err_d   = err_q;
    resp_d  = resp_q;
`ifdef SHOP_TX_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          req_d.op   = i_req_op;
          req_d.user = i_req_user;
          req_d.arg  = i_req_arg;
          req_d.num  = i_req_num;
          idx_d      = 2'd0;
          err_d      = (i_req_op == 3'd7);
          state_d    = (i_req_op == 3'd7) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
`ifdef SHOP_TX_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (i_resp_vld) begin
          resp_d = i_resp;
          if (resp_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (idx_q == last_idx) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end else begin
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end
`ifdef SHOP_TX_TIMEOUT_EN
        // A response on the limit cycle wins over the timeout.
        else if (wcnt_q == TO_LAST) begin
          resp_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_SEND;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      idx_q   <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= '0;
`ifdef SHOP_TX_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
`ifdef SHOP_TX_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rdy       = (state_q == S_SEND);
  assign o_a         = o_rdy ? tok : '0;
  assign o_u         = (o_rdy && idx_q == last_idx) ? req_q.num : '0;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;
  assign o_resp      = resp_q;

endmodule

// File: tb/tb_shop_cmd_tx.sv
// Self-checking bench for shop_cmd_tx: acts as host and shop, compares every cycle
// against a token-list/timing model derived from the command rules.
module tb_shop_cmd_tx;
  localparam int GAP = 2;
`ifdef SHOP_TX_TIMEOUT_EN
  localparam int TOC = 10;
`else
  localparam int TOC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [23:0] req_user, req_arg;
  logic [3:0]  req_num;
  logic        rdy;
  logic [23:0] a;
  logic [3:0]  u;
  logic        resp_vld;
  logic [23:0] resp, resp_o;
  logic        busy, done, err;

  always #5 clk = ~clk;

  shop_cmd_tx #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOC)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_user(req_user), .i_req_arg(req_arg), .i_req_num(req_num),
    .o_rdy(rdy), .o_a(a), .o_u(u),
    .i_resp_vld(resp_vld), .i_resp(resp), .o_resp(resp_o),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // expected outputs for the current cycle
  logic        e_ready, e_rdy, e_busy, e_done, e_err;
  logic [23:0] e_a, e_resp;
  logic [3:0]  e_u;
  // model state carried across cycles
  logic        m_err;
  logic [23:0] m_resp;

  // per-request stimulus: tokens, per-token response delay (0 = never), responses
  logic [23:0] ta[$];
  logic [3:0]  tu[$];
  int          dl[$];
  logic [23:0] rs[$];

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready", 32'(req_ready), 32'(e_ready));
      cmp("rdy",       32'(rdy),       32'(e_rdy));
      cmp("a",         32'(a),         32'(e_a));
      cmp("u",         32'(u),         32'(e_u));
      cmp("busy",      32'(busy),      32'(e_busy));
      cmp("done",      32'(done),      32'(e_done));
      cmp("err",       32'(err),       32'(e_err));
      cmp("resp",      32'(resp_o),    32'(e_resp));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic ready, input logic r, input logic [23:0] ea,
                         input logic [3:0] eu, input logic b, input logic d);
    e_ready = ready; e_rdy = r; e_a = ea; e_u = eu; e_busy = b; e_done = d;
    e_err = m_err; e_resp = m_resp;
  endtask

  function automatic logic [7:0] rchar();
    return 8'($urandom_range(65, 90));
  endfunction

  function automatic logic [23:0] rtok();
    return {rchar(), rchar(), rchar()};
  endfunction

  // Ignored-by-design response noise outside WAIT.
  task automatic noise();
    resp_vld = 1'($urandom % 2);
    resp     = ($urandom % 3 == 0) ? {8'h21, rchar(), rchar()} : rtok();
  endtask

  // Token list for a request, straight from the command table.
  task automatic build(input logic [2:0] op, input logic [23:0] usr, input logic [23:0] arg,
                       input logic [3:0] num);
    case (op)
      3'd0: ta = {24'("LGO")};
      3'd1: ta = {24'("LGI"), usr, arg};
      3'd2: ta = {24'("ADU"), usr, arg};
      3'd3: ta = {24'("DLU"), usr};
      3'd4: ta = {24'("ADI"), arg};
      3'd5: ta = {24'("DLI"), arg};
      3'd6: ta = {24'("BUY"), arg};
      default: ta = {};
    endcase
    tu = {};
    foreach (ta[i]) tu.push_back((i == ta.size() - 1) ? num : 4'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [23:0] usr, input logic [23:0] arg,
                     input logic [3:0] num);
    int n;
    bit fin;
    req_valid = 1'b1; req_op = op; req_user = usr; req_arg = arg; req_num = num;
    noise();
    set_exp(1, 0, 0, 0, 0, 0);
    step();
    req_valid = 1'b0; req_op = 3'($urandom); req_user = rtok(); req_arg = rtok(); req_num = 4'($urandom);
    m_err = 1'b0;
    n = ta.size();
    fin = 1'b0;
    if (n == 0) begin
      resp_vld = 1'b0;
      m_err = 1'b1;
      set_exp(0, 0, 0, 0, 1, 1);
      step();
      fin = 1'b1;
    end
    for (int k = 0; k < n && !fin; k++) begin
      noise();
      set_exp(0, 1, ta[k], tu[k], 1, 0);
      step();
      resp_vld = 1'b0;
      if (dl[k] == 0) begin
        for (int j = 0; j < TOC; j++) begin
          set_exp(0, 0, 0, 0, 1, 0);
          step();
        end
        m_resp = '0; m_err = 1'b1;
        set_exp(0, 0, 0, 0, 1, 1);
        step();
        fin = 1'b1;
      end else begin
        for (int j = 1; j < dl[k]; j++) begin
          set_exp(0, 0, 0, 0, 1, 0);
          step();
        end
        resp_vld = 1'b1; resp = rs[k];
        set_exp(0, 0, 0, 0, 1, 0);
        step();
        resp_vld = 1'b0;
        m_resp = rs[k];
        if (rs[k][23:16] == 8'h21 || k == n - 1) begin
          m_err = (rs[k][23:16] == 8'h21);
          set_exp(0, 0, 0, 0, 1, 1);
          step();
          fin = 1'b1;
        end else begin
          for (int g = 0; g < GAP; g++) begin
            noise();
            set_exp(0, 0, 0, 0, 1, 0);
            step();
          end
        end
      end
    end
    resp_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_user = '0; req_arg = '0; req_num = '0;
    resp_vld = 1'b0; resp = '0;
    m_err = 1'b0; m_resp = '0;
    set_exp(1, 0, 0, 0, 0, 0);
    #1 chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Login with literal tokens and 3-cycle shop latency
    ta = {24'("LGI"), 24'("Adm"), 24'("pw1")}; tu = {4'd0, 4'd0, 4'd0};
    dl = {3, 3, 3}; rs = {24'("Usr"), 24'("Usr"), 24'("Usr")};
    run(3'd1, "Adm", "pw1", 4'd0);

    // AddItem: stock rides on the last token only
    ta = {24'("ADI"), 24'("Pen")}; tu = {4'd0, 4'd7};
    dl = {2, 1}; rs = {24'("Ok1"), 24'("Ok2")};
    run(3'd4, "Xyz", "Pen", 4'd7);

    // Buy aborted by an error answer to the key
    ta = {24'("BUY"), 24'("Pen")}; tu = {4'd0, 4'd3};
    dl = {1, 1}; rs = {24'("!nv"), 24'("Zzz")};
    run(3'd6, "Xyz", "Pen", 4'd3);

    // Reserved op: no tokens, immediate error
    ta = {}; tu = {}; dl = {}; rs = {};
    run(3'd7, "Abc", "Def", 4'd1);

`ifdef SHOP_TX_TIMEOUT_EN
    ta = {24'("DLU"), 24'("Bob")}; tu = {4'd0, 4'd0};
    dl = {0, 1}; rs = {24'("Ok1"), 24'("Ok2")};
    run(3'd3, "Bob", "Qqq", 4'd0);
    dl = {TOC, 2};
    run(3'd3, "Bob", "Qqq", 4'd0);
`endif

    // Reset in the WAIT after token 1 of a Login
    req_valid = 1'b1; req_op = 3'd1; req_user = "Adm"; req_arg = "pw1"; req_num = 4'd0;
    set_exp(1, 0, 0, 0, 0, 0); step();
    req_valid = 1'b0; m_err = 1'b0;
    set_exp(0, 1, "LGI", 0, 1, 0); step();
    resp_vld = 1'b1; resp = "Usr";
    set_exp(0, 0, 0, 0, 1, 0); step();
    resp_vld = 1'b0; m_resp = "Usr";
    for (int g = 0; g < GAP; g++) begin set_exp(0, 0, 0, 0, 1, 0); step(); end
    set_exp(0, 1, "Adm", 0, 1, 0); step();
    set_exp(0, 0, 0, 0, 1, 0); step();
    rst_n = 1'b0; m_err = 1'b0; m_resp = '0;
    set_exp(1, 0, 0, 0, 0, 0); step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Randomized requests against the token-table model
    for (int it = 0; it < 40; it++) begin
      logic [2:0]  op;
      logic [23:0] usr, arg;
      logic [3:0]  num;
      op = 3'($urandom); usr = rtok(); arg = rtok(); num = 4'($urandom);
      build(op, usr, arg, num);
      dl = {}; rs = {};
      foreach (ta[i]) begin
        dl.push_back(int'($urandom_range(1, 5)));
        rs.push_back(($urandom % 6 == 0) ? {8'h21, rchar(), rchar()} : rtok());
      end
      run(op, usr, arg, num);
      for (int i = 0; i < int'($urandom % 3); i++) begin
        set_exp(1, 0, 0, 0, 0, 0); step();
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
